// File: rtl/ysyx_22041207_pkg.sv
// Shared IF/ID definitions: widths, bubble instruction, reset PC, buffer state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_22041207_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // addi x0,x0,0 -- what decode sees whenever the buffer is empty
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    // Occupancy is carried directly by the slot valids as {s_v, m_v};
    // 2'b10 (skid valid without main valid) is never legal.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } buf_state_t;

    function automatic buf_state_t occupancy(input logic m_v, input logic s_v);
        return buf_state_t'({s_v, m_v});
    endfunction

endpackage

// File: rtl/ysyx_22041207_pipe_slot.sv
// One pipeline entry: valid flag plus instruction and PC registers.
// Latency: load/clear take effect on the next rising edge.
// Backpressure: none; the owner decides when to load, clear or hold.
module ysyx_22041207_pipe_slot #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [ILEN-1:0] RST_INST = ysyx_22041207_pkg::NOP_INST,
    parameter logic [XLEN-1:0] RST_PC   = ysyx_22041207_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld,
    input  logic            clr,
    input  logic [ILEN-1:0] inst_d,
    input  logic [XLEN-1:0] pc_d,
    output logic            vld,
    output logic [ILEN-1:0] inst_q,
    output logic [XLEN-1:0] pc_q
);

    // Clear beats load so a killed entry never becomes valid; data is
    // left untouched on clear so the last PC stays visible downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld    <= 1'b0;
            inst_q <= RST_INST;
            pc_q   <= RST_PC;
        end else if (clr) begin
            vld    <= 1'b0;
        end else if (ld) begin
            vld    <= 1'b1;
            inst_q <= inst_d;
            pc_q   <= pc_d;
        end
    end

endmodule

// File: rtl/ysyx_22041207_if_id_buf.sv
// Two-entry elastic IF->ID buffer (main + skid) with flush and NOP bubble.
// Latency: accepted at edge N, visible to decode right after edge N.
// Backpressure: in_ready is a pure flop (~s_v), forced low only during rst.
module ysyx_22041207_if_id_buf #(
    parameter int              XLEN     = ysyx_22041207_pkg::XLEN,
    parameter int              ILEN     = ysyx_22041207_pkg::ILEN,
    parameter logic [ILEN-1:0] NOP_INST = ysyx_22041207_pkg::NOP_INST,
    parameter logic [XLEN-1:0] RESET_PC = ysyx_22041207_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            flush
);

    import ysyx_22041207_pkg::*;

    logic            m_v;
    logic [ILEN-1:0] m_inst;
    logic [XLEN-1:0] m_pc;
    logic            s_v;
    logic [ILEN-1:0] s_inst;
    logic [XLEN-1:0] s_pc;

    logic            accept;
    logic            deq;
    buf_state_t      state;

    logic            m_ld;
    logic            m_clr;
    logic            m_from_skid;
    logic            s_ld;
    logic            s_clr;
    logic [ILEN-1:0] m_inst_d;
    logic [XLEN-1:0] m_pc_d;

    assign in_ready  = ~s_v & ~rst;
    assign out_valid = m_v;
    assign inst_o    = m_v ? m_inst : NOP_INST;
    assign pc_o      = m_pc;

    assign accept = in_valid & in_ready;
    assign deq    = m_v & out_ready;
    assign state  = occupancy(m_v, s_v);

    // Main refills from skid when draining FULL, otherwise from fetch.
    assign m_inst_d = m_from_skid ? s_inst : inst_i;
    assign m_pc_d   = m_from_skid ? s_pc   : pc_i;

    // Next-state control: flush empties both slots; otherwise follow occupancy.
    always_comb begin
        m_ld        = 1'b0;
        m_clr       = 1'b0;
        m_from_skid = 1'b0;
        s_ld        = 1'b0;
        s_clr       = 1'b0;
        if (flush) begin
            m_clr = 1'b1;
            s_clr = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    m_ld = accept;
                end
                ONE: begin
                    if (accept && deq) begin
                        m_ld = 1'b1;
                    end else if (accept) begin
                        s_ld = 1'b1;
                    end else if (deq) begin
                        m_clr = 1'b1;
                    end
                end
                FULL: begin
                    if (deq) begin
                        m_ld        = 1'b1;
                        m_from_skid = 1'b1;
                        s_clr       = 1'b1;
                    end
                end
                default: begin
                    // unreachable encoding: drop back to EMPTY
                    m_clr = 1'b1;
                    s_clr = 1'b1;
                end
            endcase
        end
    end

    ysyx_22041207_pipe_slot #(
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .RST_INST (NOP_INST),
        .RST_PC   (RESET_PC)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .ld     (m_ld),
        .clr    (m_clr),
        .inst_d (m_inst_d),
        .pc_d   (m_pc_d),
        .vld    (m_v),
        .inst_q (m_inst),
        .pc_q   (m_pc)
    );

    ysyx_22041207_pipe_slot #(
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .RST_INST (NOP_INST),
        .RST_PC   (RESET_PC)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .ld     (s_ld),
        .clr    (s_clr),
        .inst_d (inst_i),
        .pc_d   (pc_i),
        .vld    (s_v),
        .inst_q (s_inst),
        .pc_q   (s_pc)
    );

endmodule
